// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges un-stallable ALU results with FIFO-buffered load returns
// onto the single register-file write port. Optional WB_PERF_EN adds perf counters.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        AluValid,
    input  logic [4:0]  AluRd,
    input  logic [63:0] AluResult,
    input  logic        MemValid,
    input  logic [4:0]  MemRd,
    input  logic [63:0] MemData,
    output logic        MemReady,
    output logic        StallReq,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData
`ifdef WB_PERF_EN
    ,
    output logic [31:0] KillCount,
    output logic [31:0] DropCount,
    output logic [31:0] StallCycles
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [4:0] XZR = 5'd31;

    logic [63:0]      fifo_data [DEPTH];
    logic [4:0]       fifo_rd   [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [AW:0]      wptr, rptr, occ;
    logic [CW-1:0]    starve_cnt;

    logic             alu_issue, nonempty, full, pop, head_live;
    logic             mem_accept, mem_drop, bypass, push;
    logic [DEPTH-1:0] occupied, kill_vec;

    assign occ        = wptr - rptr;
    assign full       = (occ == (AW+1)'(DEPTH));
    assign nonempty   = (occ != '0);
    assign MemReady   = !full;
    assign alu_issue  = AluValid && (AluRd != XZR);
    assign pop        = !alu_issue && nonempty;
    assign head_live  = fifo_live[rptr[AW-1:0]];
    assign mem_accept = MemValid && !full;
    // A same-cycle ALU write to the same Rd is younger, so the load is already stale.
    assign mem_drop   = mem_accept && ((MemRd == XZR) || (AluValid && (MemRd == AluRd)));
    assign bypass     = mem_accept && !mem_drop && !alu_issue && !nonempty;
    assign push       = mem_accept && !mem_drop && !bypass;

    always_comb begin
        occupied = '0;
        kill_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = ((AW+1)'(AW'(AW'(i) - rptr[AW-1:0])) < occ);
            kill_vec[i] = alu_issue && occupied[i] && fifo_live[i] && (fifo_rd[i] == AluRd);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr[AW-1:0]] <= MemData;
            fifo_rd[wptr[AW-1:0]]   <= MemRd;
        end
    end

    // Kill first so a push into the same slot (never a killed Rd) wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (kill_vec[i]) fifo_live[i] <= 1'b0;
        if (push) fifo_live[wptr[AW-1:0]] <= 1'b1;
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (alu_issue) begin
                RegWrite      <= 1'b1;
                WriteRegister <= AluRd;
                WriteData     <= AluResult;
            end else if (pop) begin
                if (head_live) begin
                    RegWrite      <= 1'b1;
                    WriteRegister <= fifo_rd[rptr[AW-1:0]];
                    WriteData     <= fifo_data[rptr[AW-1:0]];
                end
            end else if (bypass) begin
                RegWrite      <= 1'b1;
                WriteRegister <= MemRd;
                WriteData     <= MemData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            StallReq   <= 1'b0;
        end else begin
            if (!nonempty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
            StallReq <= (occ >= (AW+1)'(DEPTH - 1)) || (starve_cnt >= CW'(STARVE_LIMIT));
        end
    end

`ifdef WB_PERF_EN
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] kill_num;

    always_comb begin
        kill_num = '0;
        for (int i = 0; i < DEPTH; i++)
            kill_num = kill_num + 32'(kill_vec[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            KillCount   <= '0;
            DropCount   <= '0;
            StallCycles <= '0;
        end else begin
            KillCount   <= sat_add32(KillCount, kill_num);
            DropCount   <= sat_add32(DropCount, 32'(mem_drop));
            StallCycles <= sat_add32(StallCycles, 32'(StallReq));
        end
    end
`endif

endmodule
